// File: rtl/cdc_apb_pkg.sv
// Shared constants and types for the CDC-to-APB bridge.
//   - command opcodes carried in the first byte of a host frame
//   - status codes returned as the last byte of every response
//   - FSM state encoding used by cdc_apb_master
package cdc_apb_pkg;

    localparam logic [7:0] OP_READ    = 8'h52;  // 'R'
    localparam logic [7:0] OP_WRITE   = 8'h57;  // 'W'

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_SLVERR  = 8'h01;
    localparam logic [7:0] ST_TIMEOUT = 8'h02;
    localparam logic [7:0] ST_BADOP   = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_READ) || (b == OP_WRITE);
    endfunction

endpackage

// File: rtl/cdc_apb_master_if.sv
// Byte-stream and APB signal bundle around cdc_apb_master.
//   rx_*   : command bytes from the CDC out stream (valid/ready)
//   tx_*   : response bytes to the CDC in stream (valid/ready)
//   P*     : APB initiator port
// Modports:
//   master : view of the bridge itself
//   slave  : view of the surrounding environment (CDC core + APB fabric)
interface cdc_apb_master_if;

    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;

    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;

    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        input  rx_data_i, rx_valid_i,
        output rx_ready_o,
        output tx_data_o, tx_valid_o,
        input  tx_ready_i,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output rx_data_i, rx_valid_i,
        input  rx_ready_o,
        input  tx_data_o, tx_valid_o,
        output tx_ready_i,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/cdc_apb_resp_ser.sv
// Response serialiser: on load_i captures either 4 data bytes + status
// (with_data_i=1) or just the status byte, then presents them LSB first on
// a valid/ready stream. done_o pulses in the cycle the final byte is
// accepted; valid drops on the following edge.
// Ports:
//   clk, rst     : clock, async active-high reset
//   load_i       : capture data_i/status_i and start sending
//   with_data_i  : 1 -> 5-byte response, 0 -> status only
//   data_i       : read data, sent LSB first
//   status_i     : status byte, always last
//   tx_data_o / tx_valid_o / tx_ready_i : output stream
//   done_o       : last byte handshake this cycle
module cdc_apb_resp_ser (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        with_data_i,
    input  logic [31:0] data_i,
    input  logic [7:0]  status_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        done_o
);

    logic [4:0][7:0] resp_q, resp_d;
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      last_q, last_d;
    logic            valid_q, valid_d;
    logic            hs;

    assign hs         = valid_q & tx_ready_i;
    assign done_o     = hs && (idx_q == last_q);
    assign tx_valid_o = valid_q;
    // Output is a pure register mux, so data cannot change while stalled.
    assign tx_data_o  = resp_q[idx_q];

    always_comb begin
        resp_d  = resp_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load_i) begin
            resp_d  = with_data_i ? {status_i, data_i} : {32'h0, status_i};
            last_d  = with_data_i ? 3'd4 : 3'd0;
            idx_d   = 3'd0;
            valid_d = 1'b1;
        end else if (hs) begin
            if (idx_q == last_q) begin
                valid_d = 1'b0;
                idx_d   = 3'd0;
            end else begin
                idx_d   = idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q  <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            resp_q  <= resp_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/cdc_apb_master.sv
// Host-driven APB initiator fed by a USB CDC byte stream.
// Frame: opcode (0x52 read / 0x57 write), 4 address bytes LSB first,
// and for writes 4 data bytes LSB first. One APB transfer per frame.
// Response: reads return 4 PRDATA bytes then status, writes return status;
// an unknown opcode returns 0xFF alone.
// Ports:
//   PCLK, PRESET : single clock, async active-high reset
//   bus          : stream + APB bundle (master modport)
//   busy_o       : FSM not idle
// Parameters:
//   TIMEOUT : max ACCESS cycles without PREADY (0 = wait forever)
//   TO_W    : timeout counter width, 2**TO_W > TIMEOUT
module cdc_apb_master
    import cdc_apb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    cdc_apb_master_if.master  bus,
    output logic              busy_o
);

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [31:0]     paddr_q, paddr_d;
    logic [31:0]     pwdata_q, pwdata_d;
    logic            pwrite_q, pwrite_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [TO_W:0]   to_next;
    logic            to_hit;

    logic            rx_ready;
    logic            rx_hs;

    logic            ser_load;
    logic            ser_with;
    logic [31:0]     ser_data;
    logic [7:0]      ser_status;
    logic            ser_done;

    // Ready depends only on state (and reset), never on rx_valid_i.
    assign rx_ready = ~PRESET &
                      ((state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA));
    assign rx_hs    = bus.rx_valid_i & rx_ready;

    // One extra bit so the compare is exact even when TIMEOUT = 2**TO_W-1.
    assign to_next = {1'b0, to_q} + 1'b1;
    assign to_hit  = (TIMEOUT != 0) && (to_next == (TO_W+1)'(TIMEOUT));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pwrite_d   = pwrite_q;
        to_d       = to_q;
        ser_load   = 1'b0;
        ser_with   = 1'b0;
        ser_data   = '0;
        ser_status = ST_OK;

        case (state_q)
            S_IDLE: begin
                if (rx_hs) begin
                    if (is_opcode(bus.rx_data_i)) begin
                        pwrite_d = (bus.rx_data_i == OP_WRITE);
                        cnt_d    = 2'd0;
                        state_d  = S_ADDR;
                    end else begin
                        ser_load   = 1'b1;
                        ser_status = ST_BADOP;
                        state_d    = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_hs) begin
                    paddr_d[{cnt_q, 3'b000} +: 8] = bus.rx_data_i;
                    cnt_d = cnt_q + 2'd1;  // wraps to 0, ready for DATA
                    if (cnt_q == 2'd3)
                        state_d = pwrite_q ? S_DATA : S_SETUP;
                end
            end
            S_DATA: begin
                if (rx_hs) begin
                    pwdata_d[{cnt_q, 3'b000} +: 8] = bus.rx_data_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3)
                        state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                to_d    = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.PREADY) begin
                    ser_load   = 1'b1;
                    ser_with   = ~pwrite_q;
                    ser_data   = bus.PRDATA;
                    ser_status = bus.PSLVERR ? ST_SLVERR : ST_OK;
                    state_d    = S_RESP;
                end else if (to_hit) begin
                    // Abort: read data bytes go out as zeros.
                    ser_load   = 1'b1;
                    ser_with   = ~pwrite_q;
                    ser_status = ST_TIMEOUT;
                    state_d    = S_RESP;
                end else begin
                    to_d = to_next[TO_W-1:0];
                end
            end
            S_RESP: begin
                if (ser_done)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            to_q     <= to_d;
        end
    end

    cdc_apb_resp_ser u_ser (
        .clk         (PCLK),
        .rst         (PRESET),
        .load_i      (ser_load),
        .with_data_i (ser_with),
        .data_i      (ser_data),
        .status_i    (ser_status),
        .tx_data_o   (bus.tx_data_o),
        .tx_valid_o  (bus.tx_valid_o),
        .tx_ready_i  (bus.tx_ready_i),
        .done_o      (ser_done)
    );

    assign bus.rx_ready_o = rx_ready;
    assign bus.PADDR      = paddr_q;
    assign bus.PWDATA     = pwdata_q;
    assign bus.PWRITE     = pwrite_q;
    assign bus.PSEL       = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign bus.PENABLE    = (state_q == S_ACCESS);
    assign busy_o         = (state_q != S_IDLE);

endmodule
